// File: rtl/rysy_mem.sv
// Single-port core memory with a streaming boot-image loader.
// The core is held in reset until the loader finishes (ld_last or memory full).
module rysy_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter bit LOAD_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        err,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_ovf,
    output logic        core_hold
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [IW:0] LAST_PTR = (IW + 1)'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = LOAD_EN ? IDLE : DONE;

    logic [31:0]   mem_q [DEPTH_WORDS];
    state_t        state_q;
    logic [IW:0]   ld_ptr_q;
    logic          ld_ovf_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          in_range;
    logic [IW-1:0] word_idx;
    logic          hs;
    logic          core_we;
    logic          unused_addr;

    // Byte lane bits never affect word selection.
    assign unused_addr = ^addr[1:0];

    assign in_range  = (addr[31:IW+2] == '0);
    assign word_idx  = addr[IW+1:2];
    assign ld_ready  = (state_q != DONE);
    assign core_hold = (state_q != DONE);
    assign hs        = ld_valid & ld_ready;
    assign core_we   = we & in_range & ~core_hold & ~hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RST_STATE;
            ld_ptr_q <= '0;
            ld_ovf_q <= 1'b0;
        end else if (hs) begin
            ld_ptr_q <= ld_ptr_q + 1'b1;
            if (ld_last) begin
                state_q <= DONE;
            end else if (ld_ptr_q == LAST_PTR) begin
                state_q  <= DONE;
                ld_ovf_q <= 1'b1;
            end else begin
                state_q <= LOAD;
            end
        end
    end

    // Storage is deliberately outside reset so the image survives a core reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem_q[ld_ptr_q[IW-1:0]] <= ld_data;
        end else if (core_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= in_range ? mem_q[word_idx] : 32'h0;
            err_q   <= ~in_range;
        end
    end

    assign rdata  = rdata_q;
    assign err    = err_q;
    assign ld_ovf = ld_ovf_q;
endmodule

// File: tb/tb_rysy_mem.sv
// Directed bench for rysy_mem: a 1024-word instance and a 4-word instance for overflow.
module tb_rysy_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic        rst;
    logic [31:0] addr, wdata, ld_data;
    logic        we, ld_valid, ld_last;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err, ld_ready, ld_ovf, core_hold;

    logic        rst_b;
    logic [31:0] addr_b, wdata_b, ld_data_b;
    logic        we_b, ld_valid_b, ld_last_b;
    logic [3:0]  be_b;
    logic [31:0] rdata_b;
    logic        err_b, ld_ready_b, ld_ovf_b, core_hold_b;

    rysy_mem #(.DEPTH_WORDS(1024), .LOAD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .be(be),
        .rdata(rdata), .err(err), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_ovf(ld_ovf), .core_hold(core_hold)
    );

    rysy_mem #(.DEPTH_WORDS(4), .LOAD_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .addr(addr_b), .wdata(wdata_b), .we(we_b), .be(be_b),
        .rdata(rdata_b), .err(err_b), .ld_valid(ld_valid_b), .ld_data(ld_data_b),
        .ld_last(ld_last_b), .ld_ready(ld_ready_b), .ld_ovf(ld_ovf_b), .core_hold(core_hold_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; addr = '0; wdata = '0; we = 1'b0; be = 4'h0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        rst_b = 1'b0; addr_b = '0; wdata_b = '0; we_b = 1'b0; be_b = 4'h0;
        ld_valid_b = 1'b0; ld_data_b = '0; ld_last_b = 1'b0;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_ovf", {31'h0, ld_ovf}, 32'h0);
        chk("rst_hold", {31'h0, core_hold}, 32'h1);
        chk("rst_ready", {31'h0, ld_ready}, 32'h1);
        rst = 1'b1; rst_b = 1'b1;
        tick();

        // Boot image load
        ld_valid = 1'b1; ld_data = 32'h00500113; ld_last = 1'b0;
        tick();
        chk("load1_hold", {31'h0, core_hold}, 32'h1);
        ld_data = 32'h00000013;
        tick();
        chk("load2_ready", {31'h0, ld_ready}, 32'h1);
        ld_data = 32'hDEADBEEF; ld_last = 1'b1;
        tick();
        chk("done_hold", {31'h0, core_hold}, 32'h0);
        chk("done_ready", {31'h0, ld_ready}, 32'h0);
        chk("done_ovf", {31'h0, ld_ovf}, 32'h0);
        ld_valid = 1'b0; ld_last = 1'b0;
        addr = 32'h0; tick(); chk("rd0", rdata, 32'h00500113);
        addr = 32'h4; tick(); chk("rd4", rdata, 32'h00000013);
        addr = 32'h8; tick(); chk("rd8", rdata, 32'hDEADBEEF);
        addr = 32'hB; tick(); chk("rd8_lowbits", rdata, 32'hDEADBEEF);

        // Byte-enable write
        addr = 32'h4; we = 1'b1; be = 4'hF; wdata = 32'hDEADBEEF; tick();
        be = 4'b0101; wdata = 32'h11223344; tick();
        we = 1'b0; tick();
        chk("be_write", rdata, 32'hDE22BE44);

        // Read-before-write
        addr = 32'h8; we = 1'b1; be = 4'hF; wdata = 32'hCAFEF00D; tick();
        chk("rbw_old", rdata, 32'hDEADBEEF);
        we = 1'b0; tick();
        chk("rbw_new", rdata, 32'hCAFEF00D);

        // Empty byte-enable writes nothing
        addr = 32'h0; we = 1'b1; be = 4'h0; wdata = 32'hFFFFFFFF; tick();
        we = 1'b0; tick();
        chk("be0_nowrite", rdata, 32'h00500113);

        // Out of range write: dropped, zero data, one-cycle err
        addr = 32'h00001000; we = 1'b1; be = 4'hF; wdata = 32'h12345678; tick();
        chk("oor_rdata", rdata, 32'h0);
        chk("oor_err", {31'h0, err}, 32'h1);
        addr = 32'h0; we = 1'b0; tick();
        chk("oor_err_clr", {31'h0, err}, 32'h0);
        chk("oor_alias_w0", rdata, 32'h00500113);
        addr = 32'h4; tick(); chk("oor_w1", rdata, 32'hDE22BE44);
        addr = 32'h8; tick(); chk("oor_w2", rdata, 32'hCAFEF00D);
        addr = 32'h80000004; tick();
        chk("oor_rd_err", {31'h0, err}, 32'h1);
        chk("oor_rd_rdata", rdata, 32'h0);

        // Reset: contents survive, core writes ignored while held
        rst = 1'b0; #1;
        chk("rst2_rdata", rdata, 32'h0);
        chk("rst2_err", {31'h0, err}, 32'h0);
        chk("rst2_hold", {31'h0, core_hold}, 32'h1);
        #1 rst = 1'b1;
        addr = 32'h8; we = 1'b1; be = 4'hF; wdata = 32'h0; tick();
        chk("hold_rd", rdata, 32'hCAFEF00D);
        we = 1'b0; tick();
        chk("hold_nowrite", rdata, 32'hCAFEF00D);

        // Loader vs core on the same word
        addr = 32'h0; we = 1'b1; wdata = 32'h55555555;
        ld_valid = 1'b1; ld_data = 32'hAAAA0000; tick();
        chk("ld_rd_old", rdata, 32'h00500113);
        ld_data = 32'hBBBB1111; tick();
        chk("ld_priority", rdata, 32'hAAAA0000);
        ld_valid = 1'b0; we = 1'b0;

        // Reset mid-load
        rst = 1'b0; #1;
        chk("midrst_hold", {31'h0, core_hold}, 32'h1);
        chk("midrst_ready", {31'h0, ld_ready}, 32'h1);
        #1 rst = 1'b1;
        addr = 32'h4; ld_valid = 1'b1; ld_data = 32'hCCCC2222; ld_last = 1'b1; tick();
        chk("midrst_w1", rdata, 32'hBBBB1111);
        chk("midrst_done", {31'h0, core_hold}, 32'h0);
        ld_valid = 1'b0; ld_last = 1'b0;
        addr = 32'h0; tick(); chk("midrst_w0", rdata, 32'hCCCC2222);
        addr = 32'h8; tick(); chk("midrst_w2", rdata, 32'hCAFEF00D);

        // Overflow on the 4-word instance
        ld_valid_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_data_b = {8{i[3:0]}};
            tick();
        end
        chk("ovf_pre_ready", {31'h0, ld_ready_b}, 32'h1);
        chk("ovf_pre_flag", {31'h0, ld_ovf_b}, 32'h0);
        ld_data_b = 32'h44444444; tick();
        chk("ovf_flag", {31'h0, ld_ovf_b}, 32'h1);
        chk("ovf_ready", {31'h0, ld_ready_b}, 32'h0);
        chk("ovf_hold", {31'h0, core_hold_b}, 32'h0);
        ld_data_b = 32'h55555555; ld_last_b = 1'b1; tick();
        chk("ovf_sticky", {31'h0, ld_ovf_b}, 32'h1);
        ld_valid_b = 1'b0; ld_last_b = 1'b0;
        addr_b = 32'h0; tick(); chk("ovf_w0", rdata_b, 32'h11111111);
        addr_b = 32'h4; tick(); chk("ovf_w1", rdata_b, 32'h22222222);
        addr_b = 32'h8; tick(); chk("ovf_w2", rdata_b, 32'h33333333);
        addr_b = 32'hC; tick(); chk("ovf_w3", rdata_b, 32'h44444444);
        addr_b = 32'h10; tick();
        chk("b_oor_err", {31'h0, err_b}, 32'h1);
        chk("b_oor_rdata", rdata_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rysy_mem.md
RYSY_MEM -- requirements
Module: rysy_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter LOAD_EN, default 1, where 1 enables the loader and 0 starts in DONE with the loader inert.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  32  core byte address; word index = addr[IW+1:2], IW = log2(DEPTH_WORDS).
REQ-006 SHALL have port wdata  input  32  core write data.
REQ-007 SHALL have port we  input  1  core write strobe.
REQ-008 SHALL have port be  input  4  byte enables; be[i] selects wdata[8i+7:8i].
REQ-009 SHALL have port rdata  output  32  registered read data to core.
REQ-010 SHALL have port err  output  1  one-cycle pulse: out-of-range access.
REQ-011 SHALL have port ld_valid  input  1  loader word valid.
REQ-012 SHALL have port ld_data  input  32  loader word.
REQ-013 SHALL have port ld_last  input  1  final loader word, qualified by ld_valid.
REQ-014 SHALL have port ld_ready  output  1  loader may accept a word.
REQ-015 SHALL have port ld_ovf  output  1  sticky: image exceeded DEPTH_WORDS.
REQ-016 SHALL have port core_hold  output  1  high while image not loaded; drives the core reset request.

Function
REQ-017 SHALL treat an access as in range when addr[31:IW+2] == 0 and addr[1:0] are ignored.
REQ-018 SHALL register rdata <= mem[word index] every cycle an in-range address is presented (1-cycle latency, reads always serviced, including during core_hold).
REQ-019 SHALL return old contents on rdata when a same-cycle core write targets the read word (read-before-write).
REQ-020 SHALL, when core_hold=0, we=1 and in range, write only the bytes with be[i]=1 and leave the other bytes unchanged; be=0000 writes nothing.
REQ-021 SHALL ignore core writes while core_hold=1.
REQ-022 SHALL, for an out-of-range access (we=0 or 1), drop the write, load rdata <= 0 and pulse err=1 the next cycle only.
REQ-023 SHALL implement loader FSM states IDLE, LOAD, DONE with ld_ptr of IW+1 bits.
REQ-024 SHALL set ld_ready=1 in IDLE and LOAD and 0 in DONE, decoded from state only.
REQ-025 SHALL define a handshake as ld_valid & ld_ready, which writes ld_data (all 4 bytes) to mem[ld_ptr] and increments ld_ptr.
REQ-026 SHALL move IDLE->LOAD on a handshake with ld_last=0.
REQ-027 SHALL move IDLE or LOAD->DONE on a handshake with ld_last=1.
REQ-028 SHALL, on a handshake at ld_ptr=DEPTH_WORDS-1 with ld_last=0, write that word, go to DONE and set ld_ovf=1.
REQ-029 SHALL remain in DONE until reset and ignore ld_valid there.
REQ-030 SHALL drive core_hold=1 in IDLE and LOAD and 0 in DONE, decoded from state only.
REQ-031 SHALL give a loader handshake priority over a core write in the same cycle; the core write is dropped, which is consistent with REQ-021.
REQ-032 SHALL leave rdata unchanged in a cycle where a loader write and a core read target the same word, per REQ-019.

Reset
REQ-033 SHALL, while rst=0, asynchronously force rdata=0, err=0, ld_ovf=0, ld_ptr=0, and state=IDLE (LOAD_EN=1) or DONE (LOAD_EN=0).
REQ-034 SHALL never reset memory contents; contents SHALL survive reset.
REQ-035 SHALL, on reset mid-load, abort the load, restart at IDLE with ld_ptr=0, and set core_hold=1 immediately.
REQ-036 SHALL take effect from rst release on the first rising clk edge after deassertion.

Verification
REQ-037 SHALL cover load: after reset, 3 handshakes 0x00500113, 0x00000013, 0xDEADBEEF (last) -> DONE after the third edge, core_hold=0, ld_ready=0, and reads at addr 0/4/8 return those words one cycle later.
REQ-038 SHALL cover byte-enable write: mem[1]=0xDEADBEEF, we=1, be=0101, addr=4, wdata=0x11223344 -> addr 4 reads 0xDE22BE44.
REQ-039 SHALL cover read-before-write: same cycle we=1, be=1111, addr=8, wdata=0xCAFEF00D -> next rdata = old value, the following read = 0xCAFEF00D.
REQ-040 SHALL cover out of range: DEPTH_WORDS=1024, addr=0x00001000, we=1 -> rdata=0, err high exactly 1 cycle, and no word modified.
REQ-041 SHALL cover overflow: DEPTH_WORDS=4, 5 words streamed with ld_last only on the 5th -> 4 words written, ld_ovf=1, DONE after the 4th, and the 5th word not accepted.
REQ-042 SHALL cover reset mid-load: rst=0 after 2 handshakes -> core_hold=1, state IDLE, and the next handshake writes address 0.
